uart_rx_loader: RTL and testbench



---
 rtl/uart_rx_loader.sv | 139 +++++++++++++
 tb/tb_uart_rx_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// uart_rx_loader: 8N1 UART receiver that streams a text string and a
// search pattern, one byte per 32-bit word, into data memory.
module uart_rx_loader #(
  parameter int CLKS_PER_BIT = 100,
  parameter int ADDR_W       = 10,
  parameter int STR_BASE     = 0,
  parameter int PAT_BASE     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Rx_Serial,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       str_len,
  output logic [15:0]       pat_len,
  output logic              load_done,
  output logic              frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] STR_MAX = 17'(PAT_BASE - STR_BASE);
  localparam logic [16:0] PAT_MAX = 17'((1 << ADDR_W) - PAT_BASE);
  localparam logic [ADDR_W-1:0] SB = ADDR_W'(STR_BASE);
  localparam logic [ADDR_W-1:0] PB = ADDR_W'(PAT_BASE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {L_STR, L_PAT, L_DONE} ld_state_t;

  rx_state_t   state;
  ld_state_t   ld;
  logic        rx_m;
  logic        rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        byte_valid;

  // Good stop bit seen this cycle; shreg holds the complete byte.
  assign byte_valid = (state == STOP) && (cnt == FULL) && rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_m <= Rx_Serial;
      rx_s <= rx_m;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) state <= STOP;
            else idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            if (!rx_s) frame_err <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld        <= L_STR;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      str_len   <= '0;
      pat_len   <= '0;
      load_done <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (byte_valid) begin
        unique case (ld)
          L_STR: begin
            if (shreg == 8'h0A) begin
              ld <= L_PAT;
            end else if ({1'b0, str_len} < STR_MAX) begin
              mem_we    <= 1'b1;
              mem_addr  <= SB + str_len[ADDR_W-1:0];
              mem_wdata <= {24'b0, shreg};
              str_len   <= str_len + 16'd1;
            end
          end
          L_PAT: begin
            if (shreg == 8'h0A) begin
              ld        <= L_DONE;
              load_done <= 1'b1;
            end else if ({1'b0, pat_len} < PAT_MAX) begin
              mem_we    <= 1'b1;
              mem_addr  <= PB + pat_len[ADDR_W-1:0];
              mem_wdata <= {24'b0, shreg};
              pat_len   <= pat_len + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader: directed and randomized checks of the UART loader
// against a queue-based model of the text/pattern split.
module tb_uart_rx_loader;

  localparam int C1 = 100;
  localparam int C2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, rx1, we1, done1, ferr1;
  logic [9:0]  addr1;
  logic [31:0] wdata1;
  logic [15:0] slen1, plen1;

  logic        reset2, rx2, we2, done2, ferr2;
  logic [9:0]  addr2;
  logic [31:0] wdata2;
  logic [15:0] slen2, plen2;

  uart_rx_loader #(
    .CLKS_PER_BIT(C1), .ADDR_W(10), .STR_BASE(0), .PAT_BASE(256)
  ) dut1 (
    .clk(clk), .reset(reset1), .Rx_Serial(rx1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .str_len(slen1), .pat_len(plen1),
    .load_done(done1), .frame_err(ferr1)
  );

  uart_rx_loader #(
    .CLKS_PER_BIT(C2), .ADDR_W(10), .STR_BASE(0), .PAT_BASE(4)
  ) dut2 (
    .clk(clk), .reset(reset2), .Rx_Serial(rx2),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .str_len(slen2), .pat_len(plen2),
    .load_done(done2), .frame_err(ferr2)
  );

  int total = 0;
  int bad = 0;

  logic [9:0]  wa1[$], wa2[$];
  logic [31:0] wd1[$], wd2[$];
  logic [7:0]  ram1 [0:1023];

  always @(negedge clk) begin
    if (we1) begin
      wa1.push_back(addr1);
      wd1.push_back(wdata1);
      ram1[addr1] = wdata1[7:0];
    end
    if (we2) begin
      wa2.push_back(addr2);
      wd2.push_back(wdata2);
    end
  end

  task automatic do_reset(input bit d2);
    if (d2) reset2 = 1'b1; else reset1 = 1'b1;
    repeat (3) @(negedge clk);
    if (d2) reset2 = 1'b0; else reset1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive(input bit d2, input logic v);
    if (d2) rx2 = v; else rx1 = v;
  endtask

  task automatic send(input bit d2, input logic [7:0] b,
                      input logic stopb, input int abort_at);
    int n;
    logic [9:0] fr;
    n  = d2 ? C2 : C1;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(d2, fr[i]);
      if (i == abort_at) begin
        repeat (n / 2) @(negedge clk);
        reset1 = 1'b1;
        repeat (3) @(negedge clk);
        reset1 = 1'b0;
        drive(d2, 1'b1);
        repeat (2 * n) @(negedge clk);
        return;
      end
      repeat (n) @(negedge clk);
    end
    drive(d2, 1'b1);
  endtask

  task automatic test_reset();
    reset1 = 1'b1;
    reset2 = 1'b1;
    repeat (3) @(negedge clk);
    reset1 = 1'b0;
    reset2 = 1'b0;
    @(negedge clk);
    total++;
    if ({we1, addr1, wdata1, slen1, plen1, done1, ferr1} !== '0) begin
      bad++;
      $display("FAIL reset1 got we=%b a=%0h d=%0h s=%0d p=%0d dn=%b fe=%b want all 0",
               we1, addr1, wdata1, slen1, plen1, done1, ferr1);
    end
    total++;
    if ({we2, addr2, wdata2, slen2, plen2, done2, ferr2} !== '0) begin
      bad++;
      $display("FAIL reset2 got we=%b a=%0h d=%0h s=%0d p=%0d dn=%b fe=%b want all 0",
               we2, addr2, wdata2, slen2, plen2, done2, ferr2);
    end
  endtask

  task automatic test_glitch();
    do_reset(0);
    wa1.delete();
    wd1.delete();
    rx1 = 1'b0;
    repeat (30) @(negedge clk);
    rx1 = 1'b1;
    repeat (3 * C1) @(negedge clk);
    total++;
    if (wa1.size() != 0 || slen1 !== 16'd0) begin
      bad++;
      $display("FAIL glitch_nowrite got writes=%0d slen=%0d want 0/0",
               wa1.size(), slen1);
    end
    send(0, 8'h41, 1'b1, -1);
    repeat (C1) @(negedge clk);
    total++;
    if (wa1.size() != 1) begin
      bad++;
      $display("FAIL glitch_next_count got %0d want 1", wa1.size());
    end else if (wa1[0] !== 10'd0 || wd1[0] !== 32'h41) begin
      bad++;
      $display("FAIL glitch_next_write got a=%0h d=%0h want a=0 d=41",
               wa1[0], wd1[0]);
    end
  endtask

  task automatic test_frame_err();
    do_reset(0);
    wa1.delete();
    wd1.delete();
    send(0, 8'h55, 1'b0, -1);
    repeat (2 * C1) @(negedge clk);
    total++;
    if (ferr1 !== 1'b1 || wa1.size() != 0 || slen1 !== 16'd0) begin
      bad++;
      $display("FAIL frame_bad got fe=%b writes=%0d slen=%0d want 1/0/0",
               ferr1, wa1.size(), slen1);
    end
    send(0, 8'h62, 1'b1, -1);
    repeat (C1) @(negedge clk);
    total++;
    if (wa1.size() != 1) begin
      bad++;
      $display("FAIL frame_next_count got %0d want 1", wa1.size());
    end else if (wa1[0] !== 10'd0 || wd1[0] !== 32'h62 || ferr1 !== 1'b1) begin
      bad++;
      $display("FAIL frame_next got a=%0h d=%0h fe=%b want a=0 d=62 fe=1",
               wa1[0], wd1[0], ferr1);
    end
  endtask

  task automatic test_normal();
    logic [7:0] txt [25];
    logic [7:0] pt [5];
    pt = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61};
    for (int i = 0; i < 25; i++)
      txt[i] = (i % 6 == 1 || i % 6 == 5 || i == 24) ? 8'h62 : 8'h61;
    do_reset(0);
    wa1.delete();
    wd1.delete();
    for (int i = 0; i < 25; i++) send(0, txt[i], 1'b1, -1);
    send(0, 8'h0A, 1'b1, -1);
    for (int i = 0; i < 5; i++) send(0, pt[i], 1'b1, -1);
    send(0, 8'h0A, 1'b1, -1);
    repeat (C1) @(negedge clk);
    total++;
    if (wa1.size() != 30) begin
      bad++;
      $display("FAIL normal_count got %0d want 30", wa1.size());
    end
    total++;
    if (ram1[0] !== 8'h61 || ram1[1] !== 8'h62 || ram1[24] !== 8'h62 ||
        ram1[256] !== 8'h61 || ram1[260] !== 8'h61) begin
      bad++;
      $display("FAIL normal_ram got %0h %0h %0h %0h %0h want 61 62 62 61 61",
               ram1[0], ram1[1], ram1[24], ram1[256], ram1[260]);
    end
    for (int i = 0; i < 25; i++) begin
      total++;
      if (ram1[i] !== txt[i]) begin
        bad++;
        $display("FAIL normal_text[%0d] got %0h want %0h", i, ram1[i], txt[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ram1[256+i] !== pt[i]) begin
        bad++;
        $display("FAIL normal_pat[%0d] got %0h want %0h", i, ram1[256+i], pt[i]);
      end
    end
    total++;
    if (slen1 !== 16'd25 || plen1 !== 16'd5 || done1 !== 1'b1 || ferr1 !== 1'b0) begin
      bad++;
      $display("FAIL normal_status got s=%0d p=%0d dn=%b fe=%b want 25/5/1/0",
               slen1, plen1, done1, ferr1);
    end
  endtask

  task automatic test_post_done();
    wa1.delete();
    wd1.delete();
    send(0, 8'h63, 1'b1, -1);
    send(0, 8'h0A, 1'b1, -1);
    repeat (C1) @(negedge clk);
    total++;
    if (wa1.size() != 0 || slen1 !== 16'd25 || plen1 !== 16'd5 || done1 !== 1'b1) begin
      bad++;
      $display("FAIL post_done got writes=%0d s=%0d p=%0d dn=%b want 0/25/5/1",
               wa1.size(), slen1, plen1, done1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    send(0, 8'h61, 1'b1, -1);
    send(0, 8'h62, 1'b1, -1);
    send(0, 8'h61, 1'b1, 5);
    total++;
    if ({we1, addr1, wdata1, slen1, plen1, done1, ferr1} !== '0) begin
      bad++;
      $display("FAIL reset_mid got we=%b a=%0h d=%0h s=%0d p=%0d dn=%b fe=%b want all 0",
               we1, addr1, wdata1, slen1, plen1, done1, ferr1);
    end
    wa1.delete();
    wd1.delete();
    send(0, 8'h0A, 1'b1, -1);
    send(0, 8'h0A, 1'b1, -1);
    repeat (C1) @(negedge clk);
    total++;
    if (wa1.size() != 0 || slen1 !== 16'd0 || plen1 !== 16'd0 || done1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_empty got writes=%0d s=%0d p=%0d dn=%b want 0/0/0/1",
               wa1.size(), slen1, plen1, done1);
    end
  endtask

  task automatic test_overflow();
    do_reset(1);
    wa2.delete();
    wd2.delete();
    for (int i = 0; i < 6; i++) send(1, 8'h30 + 8'(i), 1'b1, -1);
    repeat (4 * C2) @(negedge clk);
    total++;
    if (wa2.size() != 4 || slen2 !== 16'd4) begin
      bad++;
      $display("FAIL overflow got writes=%0d slen=%0d want 4/4", wa2.size(), slen2);
    end
    for (int i = 0; i < 4 && i < wa2.size(); i++) begin
      total++;
      if (wa2[i] !== 10'(i) || wd2[i] !== 32'h30 + 32'(i)) begin
        bad++;
        $display("FAIL overflow_w%0d got a=%0h d=%0h want a=%0h d=%0h",
                 i, wa2[i], wd2[i], i, 8'h30 + i);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [7:0] txt[$];
      logic [7:0] pt[$];
      logic [7:0] seq[$];
      logic [9:0] ea[$];
      logic [31:0] ed[$];
      logic [7:0] b;
      int tlen, plen, extra, ns;
      tlen  = $urandom_range(0, 7);
      plen  = $urandom_range(0, 6);
      extra = $urandom_range(0, 2);
      for (int i = 0; i < tlen; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0A) b = 8'h0D;
        txt.push_back(b);
      end
      for (int i = 0; i < plen; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0A) b = 8'h0B;
        pt.push_back(b);
      end
      seq = {txt, 8'h0A, pt, 8'h0A};
      for (int i = 0; i < extra; i++) seq.push_back(8'($urandom_range(0, 255)));
      // Text fills words 0..3 only; pattern starts at word 4.
      ns = (tlen < 4) ? tlen : 4;
      for (int i = 0; i < ns; i++) begin
        ea.push_back(10'(i));
        ed.push_back({24'b0, txt[i]});
      end
      for (int i = 0; i < plen; i++) begin
        ea.push_back(10'(4 + i));
        ed.push_back({24'b0, pt[i]});
      end
      do_reset(1);
      wa2.delete();
      wd2.delete();
      foreach (seq[i]) send(1, seq[i], 1'b1, -1);
      repeat (4 * C2) @(negedge clk);
      total++;
      if (wa2.size() != ea.size()) begin
        bad++;
        $display("FAIL rand%0d_count got %0d want %0d", r, wa2.size(), ea.size());
      end
      for (int i = 0; i < ea.size() && i < wa2.size(); i++) begin
        total++;
        if (wa2[i] !== ea[i] || wd2[i] !== ed[i]) begin
          bad++;
          $display("FAIL rand%0d_w%0d got a=%0h d=%0h want a=%0h d=%0h",
                   r, i, wa2[i], wd2[i], ea[i], ed[i]);
        end
      end
      total++;
      if (slen2 !== 16'(ns) || plen2 !== 16'(plen) || done2 !== 1'b1 || ferr2 !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d_status got s=%0d p=%0d dn=%b fe=%b want %0d/%0d/1/0",
                 r, slen2, plen2, done2, ferr2, ns, plen);
      end
    end
  endtask

  initial begin
    rx1    = 1'b1;
    rx2    = 1'b1;
    reset1 = 1'b1;
    reset2 = 1'b1;
    test_reset();
    test_glitch();
    test_frame_err();
    test_normal();
    test_post_done();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
